// File: rtl/timer_param_counter.sv
// rtl/timer_param_counter.sv - WIDTH-bit timer with clock-select prescaler, CTC mode and NUM_CMP compare channels
// Optional macro TIMER_PARAM_EXT_CLK_EN builds the ext_clk synchroniser for CS 6/7.
module timer_param_counter #(
  parameter int WIDTH   = 16,
  parameter int NUM_CMP = 2
) (
  input  logic               sysClock,
  input  logic               system_reset,
  input  logic [2:0]         reg_addr,
  input  logic [WIDTH-1:0]   reg_wdata,
  input  logic               reg_we,
  output logic [WIDTH-1:0]   reg_rdata,
  input  logic               ext_clk,
  output logic               irq,
  output logic [NUM_CMP-1:0] compare_match
);

  localparam int FW = NUM_CMP + 1;

  logic [WIDTH-1:0]   tcnt;
  logic [3:0]         tccr;
  logic [FW-1:0]      timsk;
  logic [FW-1:0]      tifr;
  logic [WIDTH-1:0]   ocr [NUM_CMP];
  logic [9:0]         presc;
  logic               ext_rise;
  logic               ext_fall;

`ifdef TIMER_PARAM_EXT_CLK_EN
  logic ext_s1, ext_s2, ext_prev;

  always_ff @(posedge sysClock or posedge system_reset) begin
    if (system_reset) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_prev <= 1'b0;
    end else begin
      ext_s1   <= ext_clk;
      ext_s2   <= ext_s1;
      ext_prev <= ext_s2;
    end
  end

  assign ext_rise = ext_s2 & ~ext_prev;
  assign ext_fall = ~ext_s2 & ext_prev;
`else
  logic unused_ext;
  assign unused_ext = ext_clk;
  assign ext_rise   = 1'b0;
  assign ext_fall   = 1'b0;
`endif

  logic wr_tcnt, wr_tccr, wr_timsk, wr_tifr;
  assign wr_tcnt  = reg_we && (reg_addr == 3'd0);
  assign wr_tccr  = reg_we && (reg_addr == 3'd1);
  assign wr_timsk = reg_we && (reg_addr == 3'd2);
  assign wr_tifr  = reg_we && (reg_addr == 3'd3);

  // tick fires in the cycle whose closing edge wraps the low prescaler bits
  logic tick;
  always_comb begin
    tick = 1'b0;
    case (tccr[2:0])
      3'd1:    tick = 1'b1;
      3'd2:    tick = (presc[2:0] == 3'h7);
      3'd3:    tick = (presc[5:0] == 6'h3f);
      3'd4:    tick = (presc[7:0] == 8'hff);
      3'd5:    tick = (presc == 10'h3ff);
      3'd6:    tick = ext_fall;
      3'd7:    tick = ext_rise;
      default: tick = 1'b0;
    endcase
  end

  logic               cnt_tick;
  logic               ctc_clear;
  logic               tov_set;
  logic [NUM_CMP-1:0] cmp_hit;
  logic [FW-1:0]      tifr_clr;
  logic [FW-1:0]      tifr_next;

  always_comb begin
    cnt_tick  = tick && !wr_tcnt;
    ctc_clear = tccr[3] && (tcnt == ocr[0]);
    tov_set   = cnt_tick && !tccr[3] && (tcnt == {WIDTH{1'b1}});
    for (int i = 0; i < NUM_CMP; i++)
      cmp_hit[i] = cnt_tick && (tcnt == ocr[i]);
    tifr_clr  = wr_tifr ? reg_wdata[FW-1:0] : '0;
    // hardware set is OR'd after the clear so it wins a same-cycle W1C
    tifr_next = (tifr & ~tifr_clr) | {cmp_hit, tov_set};
  end

  always_ff @(posedge sysClock or posedge system_reset) begin
    if (system_reset) begin
      tcnt          <= '0;
      tccr          <= '0;
      timsk         <= '0;
      tifr          <= '0;
      presc         <= '0;
      compare_match <= '0;
      for (int i = 0; i < NUM_CMP; i++) ocr[i] <= '0;
    end else begin
      presc         <= wr_tccr ? 10'd0 : presc + 10'd1;
      tifr          <= tifr_next;
      compare_match <= cmp_hit;
      if (wr_tccr)  tccr  <= reg_wdata[3:0];
      if (wr_timsk) timsk <= reg_wdata[FW-1:0];
      if (wr_tcnt)
        tcnt <= reg_wdata;
      else if (tick)
        tcnt <= ctc_clear ? '0 : tcnt + 1'b1;
      for (int i = 0; i < NUM_CMP; i++)
        if (reg_we && (reg_addr == 3'(4 + i))) ocr[i] <= reg_wdata;
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0: reg_rdata = tcnt;
      3'd1: reg_rdata = WIDTH'(tccr);
      3'd2: reg_rdata = WIDTH'(timsk);
      3'd3: reg_rdata = WIDTH'(tifr);
      default: begin
        for (int i = 0; i < NUM_CMP; i++)
          if (reg_addr == 3'(4 + i)) reg_rdata = ocr[i];
      end
    endcase
  end

  assign irq = |(tifr & timsk);

endmodule

// File: tb/tb_timer_param_counter.sv
// tb/tb_timer_param_counter.sv - directed self-checking bench for timer_param_counter
module tb_timer_param_counter;

  logic        sysClock;
  logic        system_reset;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic [15:0] reg_rdata;
  logic        ext_clk;
  logic        irq;
  logic [1:0]  compare_match;

  timer_param_counter #(.WIDTH(16), .NUM_CMP(2)) dut (
    .sysClock      (sysClock),
    .system_reset  (system_reset),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_rdata     (reg_rdata),
    .ext_clk       (ext_clk),
    .irq           (irq),
    .compare_match (compare_match)
  );

  initial begin
    sysClock = 1'b0;
    forever #5 sysClock = ~sysClock;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    @(posedge sysClock);
    #1;
    reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    reg_addr = a;
    #1;
    v = reg_rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysClock);
    #1;
  endtask

  logic [15:0] v;

  initial begin
    vecs[0] = '{3'd4, 16'h1234, 3'd4, 16'h1234};
    vecs[1] = '{3'd5, 16'hBEEF, 3'd5, 16'hBEEF};
    vecs[2] = '{3'd2, 16'hFFFF, 3'd2, 16'h0007};
    vecs[3] = '{3'd1, 16'hFFF8, 3'd1, 16'h0008};
    vecs[4] = '{3'd6, 16'h0055, 3'd6, 16'h0000};
    vecs[5] = '{3'd7, 16'h00AA, 3'd7, 16'h0000};
    vecs[6] = '{3'd0, 16'hABCD, 3'd0, 16'hABCD};
    vecs[7] = '{3'd1, 16'h0000, 3'd1, 16'h0000};
    vecs[8] = '{3'd2, 16'h0000, 3'd2, 16'h0000};
    vecs[9] = '{3'd0, 16'h0000, 3'd0, 16'h0000};

    system_reset = 1'b1;
    reg_addr     = 3'd0;
    reg_wdata    = 16'h0;
    reg_we       = 1'b0;
    ext_clk      = 1'b0;
    cycles(3);
    system_reset = 1'b0;
    cycles(1);

    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v);
      chk($sformatf("reset_reg%0d", a), v, 0);
    end
    chk("reset_irq", irq, 0);
    chk("reset_cm", compare_match, 0);

    foreach (vecs[i]) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // overflow after 65536 ticks at /1
    wr(3'd1, 16'h0001);
    cycles(65535);
    rd(3'd0, v);
    chk("ovf_tcnt_pre", v, 16'hFFFF);
    cycles(1);
    rd(3'd0, v);
    chk("ovf_tcnt", v, 16'h0000);
    rd(3'd3, v);
    chk("ovf_tov", v[0], 1);
    chk("ovf_irq_masked", irq, 0);
    wr(3'd1, 16'h0000);
    wr(3'd3, 16'h0001);
    rd(3'd3, v);
    chk("ovf_tov_clr", v[0], 0);
    chk("ovf_irq_after", irq, 0);

    // CTC with OCR0=9
    wr(3'd3, 16'h0007);
    wr(3'd0, 16'h0000);
    wr(3'd4, 16'h0009);
    wr(3'd2, 16'h0002);
    wr(3'd1, 16'h0009);
    for (int k = 1; k <= 30; k++) begin
      @(posedge sysClock);
      #1;
      rd(3'd0, v);
      chk($sformatf("ctc_tcnt_%0d", k), v, 16'(k % 10));
      chk($sformatf("ctc_cm0_%0d", k), compare_match[0], (k % 10) == 0);
      if (k == 9)  chk("ctc_irq_before", irq, 0);
      if (k == 10) chk("ctc_irq", irq, 1);
    end
    rd(3'd3, v);
    chk("ctc_flags", v[1:0], 2'b10);
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0000);

    // /64 prescaler
    wr(3'd3, 16'h0007);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0003);
    cycles(63);
    rd(3'd0, v);
    chk("div64_63", v, 16'd0);
    cycles(1);
    rd(3'd0, v);
    chk("div64_64", v, 16'd1);
    cycles(576);
    rd(3'd0, v);
    chk("div64_640", v, 16'd10);
    wr(3'd1, 16'h0000);

    // TCNT write in a tick cycle suppresses the compare
    wr(3'd3, 16'h0007);
    wr(3'd5, 16'h0100);
    wr(3'd0, 16'h0100);
    wr(3'd1, 16'h0001);
    wr(3'd0, 16'h0100);
    rd(3'd0, v);
    chk("tw_tcnt", v, 16'h0100);
    rd(3'd3, v);
    chk("tw_no_ocf1", v[2], 0);
    chk("tw_no_cm1", compare_match[1], 0);
    cycles(1);
    rd(3'd3, v);
    chk("tw_ocf1_next", v[2], 1);
    chk("tw_cm1_next", compare_match[1], 1);
    wr(3'd1, 16'h0000);

    // W1C loses to a same-cycle match
    wr(3'd3, 16'h0007);
    wr(3'd0, 16'h0005);
    wr(3'd4, 16'h0005);
    wr(3'd1, 16'h0001);
    wr(3'd3, 16'h0002);
    rd(3'd3, v);
    chk("w1c_race_ocf0", v[1], 1);
    wr(3'd1, 16'h0000);
    wr(3'd3, 16'h0002);
    rd(3'd3, v);
    chk("w1c_plain_ocf0", v[1], 0);

    // external clock, rising edges
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0007);
    for (int e = 0; e < 5; e++) begin
      ext_clk = 1'b1;
      cycles(4);
      ext_clk = 1'b0;
      cycles(4);
    end
    cycles(5);
    rd(3'd0, v);
`ifdef TIMER_PARAM_EXT_CLK_EN
    chk("ext_count", v, 16'd5);
`else
    chk("ext_count", v, 16'd0);
`endif
    wr(3'd1, 16'h0000);

    // reset asserted mid-count
    wr(3'd2, 16'h0007);
    wr(3'd4, 16'h0003);
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0001);
    cycles(6);
    rd(3'd3, v);
    chk("pre_rst_irq", irq, 1);
    #2;
    system_reset = 1'b1;
    #1;
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v);
      chk($sformatf("midrst_reg%0d", a), v, 0);
    end
    chk("midrst_irq", irq, 0);
    chk("midrst_cm", compare_match, 0);
    system_reset = 1'b0;
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_param_counter.md
# timer_param_counter

Parametrised successor to the fixed 16-bit timer register block. It provides a WIDTH-bit up-counter with an AVR-style clock-select prescaler and NUM_CMP output-compare channels. It supports normal and CTC (clear-on-match-0) modes, write-1-to-clear interrupt flags, and a masked interrupt request. It sits on the peripheral register bus beside the 8-bit and 16-bit timers and drives one interrupt line into the interrupt controller.

## Interface
- WIDTH, 16, counter, OCR and TCNT width (8..32)
- NUM_CMP, 2, number of compare channels (1..4)
- sysClock  input  1  system clock, all state on rising edge
- system_reset  input  1  asynchronous, active-high reset
- reg_addr  input  3  register select: 0 TCNT, 1 TCCR, 2 TIMSK, 3 TIFR, 4+i OCR[i]
- reg_wdata  input  WIDTH  write data (TCCR/TIMSK/TIFR use low bits)
- reg_we  input  1  write strobe, one write per cycle
- reg_rdata  output  WIDTH  combinational read of the selected register; 0 for unused addresses
- ext_clk  input  1  asynchronous external count source
- irq  output  1  OR of (TIFR & TIMSK), registered-source combinational
- compare_match  output  NUM_CMP  one-cycle pulse per channel on match

## Operation
- TCCR bits: [2:0] CS, [3] CTC; other bits read 0.
- CS encoding: 0 stopped; 1 /1; 2 /8; 3 /64; 4 /256; 5 /1024; 6 ext_clk falling; 7 ext_clk rising.
- Prescaler: 10-bit free-running counter. It clears when TCCR is written. tick asserts when the low log2(N) bits wrap to 0.
- On tick with TCNT == OCR[0] and CTC=1: TCNT ← 0 and no TOV. Otherwise, on tick TCNT ← TCNT+1 modulo 2^WIDTH.
- TOV (TIFR bit 0) sets on tick when TCNT == all-ones and CTC=0.
- OCF[i] (TIFR bit i+1) sets on tick when the pre-tick TCNT == OCR[i]. compare_match[i] pulses in the same cycle.
- TIFR write: each 1 bit clears the corresponding flag; 0 bits have no effect. Bits above NUM_CMP read 0.
- TIMSK: same bit layout as TIFR.
- Priority:
  - A TCNT write overrides a same-cycle tick. Compare and TOV are suppressed for that cycle.
  - A hardware flag set wins over a same-cycle W1C clear of the same bit.
- OCR writes take effect immediately; there is no double buffering.
- If OCR[0]=0 in CTC mode, TCNT stays 0 and OCF0 sets every tick.
- Reset, including reset asserted mid-count: TCNT, TCCR, TIMSK, TIFR, all OCR and the prescaler go to 0. irq=0, compare_match=0, reg_rdata=0.

## Timing
- The write takes effect at the sysClock edge where reg_we=1. reg_rdata reflects the new value in the next cycle.
- CS=1: one tick per cycle. CS=N (divide): the first tick is N cycles after the TCCR write edge, then every N cycles.
- External source: 2-flop synchroniser plus edge register. tick asserts 3 sysClock cycles after the ext_clk edge.
- ext_clk must stay stable at least 2 sysClock periods per level; faster edges may be lost.
- Flag set and compare_match are visible the cycle after the tick edge. irq follows combinationally.

## Configuration
- TIMER_PARAM_EXT_CLK_EN defined: the external clock synchroniser is built and CS 6/7 count ext_clk edges.
- Without TIMER_PARAM_EXT_CLK_EN: no synchroniser, ext_clk is ignored, and CS 6/7 behave as stopped.

## Test plan
- Reset, then CS=1, WIDTH=16: after 65536 cycles TCNT=0 and TOV=1. Writing TIFR=0x1 clears TOV and irq stays 0 with TIMSK=0.
- CS=1, CTC=1, OCR[0]=9, TIMSK=0x2: TCNT cycles 0..9. OCF0 sets every 10 cycles, irq=1, and TOV is never set.
- CS=3 (/64): TCNT increments exactly once per 64 cycles. After 640 cycles TCNT=10.
- Write TCNT=OCR[1]=0x100 in the same cycle as a tick: there is no OCF1 that cycle. TCNT=0x100 is read back, and OCF1 sets on the next tick.
- Hold a W1C of OCF0 in the same cycle as a match: OCF0 remains 1.
- With the _EN macro: 5 rising ext_clk edges with CS=7 → TCNT=5. Without it, TCNT stays 0.
